// File: rtl/dst7_32_in_gather_if.sv
// Handshake bundle between the residual producer, the gather stage and the DST-VII core.
// Input beats arrive on in_*; complete vectors leave on out_*.
interface dst7_32_in_gather_if #(
  parameter int N     = 32,
  parameter int W     = 9,
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*W-1:0]   in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*W-1:0]       out_x;
  logic                 err_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_x, err_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_x, err_len
  );
endinterface

// File: rtl/dst7_32_in_gather.sv
// Double-buffered gather of LANES-wide residual beats into N-sample vectors for the DST-VII core.
// One bank fills while the other is held on out_x until the consumer takes it.
module dst7_32_in_gather #(
  parameter int N     = 32,
  parameter int W     = 9,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dst7_32_in_gather_if.slave   bus
);
  localparam int BEATS = N / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  logic [W-1:0]  r_bank [2][N];
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [CW-1:0] r_beat_cnt;
  logic [1:0]    r_full_cnt;
  logic          r_err_len;

  logic          w_accept;
  logic          w_last_beat;
  logic          w_fill;
  logic          w_pop;
  logic          w_frame_bad;
  logic [CW-1:0] w_beat_next;
  logic [1:0]    w_full_next;

  // Ready depends only on registered occupancy, never on out_ready.
  assign bus.in_ready  = (r_full_cnt != 2'd2);
  assign bus.out_valid = (r_full_cnt != 2'd0);
  assign bus.err_len   = r_err_len;

  always_comb begin
    w_accept    = bus.in_valid && (r_full_cnt != 2'd2);
    w_last_beat = (r_beat_cnt == LAST_BEAT);
    w_fill      = w_accept && w_last_beat;
    w_pop       = (r_full_cnt != 2'd0) && bus.out_ready;
    w_frame_bad = w_accept && (bus.in_last != w_last_beat);
    w_beat_next = r_beat_cnt;
    if (w_accept) begin
      w_beat_next = w_last_beat ? '0 : r_beat_cnt + 1'b1;
    end
    w_full_next = r_full_cnt;
    case ({w_fill, w_pop})
      2'b10:   w_full_next = r_full_cnt + 2'd1;
      2'b01:   w_full_next = r_full_cnt - 2'd1;
      default: w_full_next = r_full_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_beat_cnt <= '0;
      r_full_cnt <= 2'd0;
      r_err_len  <= 1'b0;
    end else begin
      r_beat_cnt <= w_beat_next;
      r_full_cnt <= w_full_next;
      if (w_fill) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_pop) begin
        r_rd_bank <= ~r_rd_bank;
      end
      if (w_frame_bad) begin
        r_err_len <= 1'b1;
      end
    end
  end

  // Bank storage is never reset; a partial frame is simply overwritten by the next one.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < LANES; k++) begin
        r_bank[r_wr_bank][IW'(int'(r_beat_cnt) * LANES + k)] <= bus.in_data[k*W +: W];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_out
      assign bus.out_x[gi*W +: W] = r_bank[r_rd_bank][gi];
    end
  endgenerate
endmodule

// File: tb/tb_dst7_32_in_gather.sv
// Scoreboard bench for dst7_32_in_gather: driver pushes expected vectors, monitor pops on each handshake.
module tb_dst7_32_in_gather;
  localparam int N     = 32;
  localparam int W     = 9;
  localparam int LANES = 4;
  localparam int BEATS = N / LANES;
  localparam int VW    = N * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dst7_32_in_gather_if #(.N(N), .W(W), .LANES(LANES)) ifc ();
  dst7_32_in_gather #(.N(N), .W(W), .LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int n_checks = 0;
  int n_fail   = 0;
  logic [VW-1:0] exp_q [$];

  task automatic chk(input string name, input integer act, input integer exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s vector matches", name);
    end
  endtask

  function automatic logic [VW-1:0] mk_const(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] mk_ramp();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(i - 16);
    return r;
  endfunction

  // Drive nb beats of vec; bad marks an early in_last; rdy_last raises out_ready with the final beat.
  task automatic send_beats(input logic [VW-1:0] vec, input int nb, input int bad, input bit rdy_last);
    for (int b = 0; b < nb; b++) begin
      int  waited;
      bit  acc;
      ifc.in_valid = 1'b1;
      ifc.in_data  = vec[b*LANES*W +: LANES*W];
      ifc.in_last  = (b == BEATS - 1) || (b == bad);
      if (rdy_last && b == BEATS - 1) ifc.out_ready = 1'b1;
      waited = 0;
      do begin
        acc = ifc.in_ready;
        @(posedge clk);
        #1;
        waited++;
      end while (!acc && waited < 200);
      if (!acc) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_accept_timeout: beat %0d not accepted after %0d cycles, expected acceptance", b, waited);
      end
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    if (nb == BEATS) exp_q.push_back(vec);
  endtask

  task automatic drain();
    int c;
    ifc.out_ready = 1'b1;
    c = 0;
    while ((exp_q.size() != 0 || ifc.out_valid) && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  initial begin
    logic [VW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_vector: got %h, expected no output", ifc.out_x);
        end else begin
          e = exp_q.pop_front();
          chk_vec("popped_vector", ifc.out_x, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] vec_a;
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", ifc.in_ready, 1);
    chk("reset_out_valid", ifc.out_valid, 0);
    chk("reset_err_len", ifc.err_len, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single ramp vector with consumer ready.
    ifc.out_ready = 1'b1;
    send_beats(mk_ramp(), BEATS, -1, 1'b0);
    chk("single_out_valid", ifc.out_valid, 1);
    v = ifc.out_x;
    chk("single_x0", integer'($signed(v[0*W +: W])), -16);
    chk("single_x5", integer'($signed(v[5*W +: W])), -11);
    chk("single_x31", integer'($signed(v[31*W +: W])), 15);
    @(posedge clk);
    #1;
    chk("single_popped_out_valid", ifc.out_valid, 0);

    // Backpressure: two vectors fill both banks, third stalls.
    ifc.out_ready = 1'b0;
    vec_a = mk_const(1);
    send_beats(vec_a, BEATS, -1, 1'b0);
    send_beats(mk_const(-1), BEATS, -1, 1'b0);
    chk("bp_in_ready_full", ifc.in_ready, 0);
    chk("bp_out_valid", ifc.out_valid, 1);
    fork
      send_beats(mk_const(255), BEATS, -1, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_stalled", ifc.in_ready, 0);
        chk_vec("bp_held_a", ifc.out_x, vec_a);
        ifc.out_ready = 1'b1;
      end
    join
    drain();

    // Concurrent fill-complete and pop.
    ifc.out_ready = 1'b0;
    send_beats(mk_ramp(), BEATS, -1, 1'b0);
    send_beats(mk_const(-100), BEATS, -1, 1'b1);
    chk("conc_out_valid", ifc.out_valid, 1);
    chk("conc_in_ready", ifc.in_ready, 1);
    chk_vec("conc_out_x_new", ifc.out_x, mk_const(-100));
    drain();

    // Framing: early in_last on beat 3.
    ifc.out_ready = 1'b1;
    chk("frame_err_before", ifc.err_len, 0);
    send_beats(mk_const(3), BEATS, 3, 1'b0);
    chk("frame_err_set", ifc.err_len, 1);
    send_beats(mk_const(-5), BEATS, -1, 1'b0);
    chk("frame_err_sticky", ifc.err_len, 1);
    drain();

    // Reset mid-frame, asserted between clock edges.
    ifc.out_ready = 1'b0;
    send_beats(mk_const(100), 5, -1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", ifc.in_ready, 1);
    chk("midrst_out_valid", ifc.out_valid, 0);
    chk("midrst_err_len", ifc.err_len, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    send_beats(mk_const(-256), BEATS, -1, 1'b0);
    chk_vec("midrst_clean_vector", ifc.out_x, mk_const(-256));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
